// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute and
// stalls on mem_ready. Define MC_BNE_EN to have the branch state also handle bne.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;
  logic       branch_taken;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifdef MC_BNE_EN
  always_comb begin
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = ~Zero;
      default: branch_taken = 1'b0;
    endcase
  end
`else
  assign branch_taken = Zero;
`endif

  // Raw (pre-reset-gating) outputs and next state; every field defaults to 0.
  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    AdrSrc        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA      = 2'b10;
        alu_op       = 2'b01;
        pc_write_raw = branch_taken;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
        state_d      = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

  // Reset cycle suppresses every side effect, including an in-flight store.
  assign PCWrite  = reset & pc_write_raw;
  assign MemWrite = reset & mem_write_raw;
  assign IRWrite  = reset & ir_write_raw;
  assign RegWrite = reset & reg_write_raw;
  assign illegal  = reset & illegal_raw;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by
// cycle and compares all outputs against hand-computed values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MW = 4'd5, XR = 4'd6, XI = 4'd7, AWB = 4'd8, BQ = 4'd9, JL = 4'd10;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // we = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal}
  task automatic step(input string tag, input logic [3:0] st, input logic [5:0] we,
                      input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [2:0] alu, input logic [1:0] imm);
    @(negedge clk);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".we"}, 32'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal}), 32'(we));
    chk({tag, ".rsrc"}, 32'(ResultSrc), 32'(rs));
    chk({tag, ".srca"}, 32'(ALUSrcA), 32'(sa));
    chk({tag, ".srcb"}, 32'(ALUSrcB), 32'(sb));
    chk({tag, ".aluc"}, 32'(ALUControl), 32'(alu));
    chk({tag, ".imm"}, 32'(ImmSrc), 32'(imm));
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; Zero = 1'b1;
    set_instr(7'b0100011, 3'b010, 1'b1);
    // Reset held low two cycles: state FETCH, no write enables despite mem_ready
    step("rst0", FE, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    step("rst1", FE, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    reset = 1'b1; Zero = 1'b0;

    // lw
    set_instr(7'b0000011, 3'b010, 1'b0);
    step("lw.fe", FE,  6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    step("lw.de", DE,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    step("lw.ma", MA,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    step("lw.mr", MR,  6'b010000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    step("lw.wb", MWB, 6'b000010, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00);

    // FETCH stall, then sw with three not-ready MEMWRITE cycles
    set_instr(7'b0100011, 3'b010, 1'b0);
    mem_ready = 1'b0;
    step("sw.fs", FE, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    mem_ready = 1'b1;
    step("sw.fe", FE, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    step("sw.de", DE, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01);
    step("sw.ma", MA, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01);
    mem_ready = 1'b0;
    step("sw.w0", MW, 6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    step("sw.w1", MW, 6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    step("sw.w2", MW, 6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    mem_ready = 1'b1;
    step("sw.w3", MW, 6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);

    // R-type sub
    set_instr(7'b0110011, 3'b000, 1'b1);
    step("sub.fe", FE,  6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    step("sub.de", DE,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    step("sub.ex", XR,  6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00);
    step("sub.wb", AWB, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);

    // addi with funct7b5 set must still add (op[5]=0)
    set_instr(7'b0010011, 3'b000, 1'b1);
    step("addi.fe", FE,  6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    step("addi.de", DE,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    step("addi.ex", XI,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00);
    step("addi.wb", AWB, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);

    // slt, then or
    set_instr(7'b0110011, 3'b010, 1'b0);
    step("slt.fe", FE,  6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    step("slt.de", DE,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    step("slt.ex", XR,  6'b000000, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00);
    step("slt.wb", AWB, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    set_instr(7'b0110011, 3'b110, 1'b0);
    step("or.fe", FE,  6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    step("or.de", DE,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);
    step("or.ex", XR,  6'b000000, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00);
    step("or.wb", AWB, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);

    // beq taken / not taken
    set_instr(7'b1100011, 3'b000, 1'b0);
    Zero = 1'b1;
    step("beqt.fe", FE, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10);
    step("beqt.de", DE, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10);
    step("beqt.bq", BQ, 6'b100000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10);
    Zero = 1'b0;
    step("beqn.fe", FE, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10);
    step("beqn.de", DE, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10);
    step("beqn.bq", BQ, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10);

    // bne, Zero=0: taken only when the bne option is built in
    set_instr(7'b1100011, 3'b001, 1'b0);
    step("bne.fe", FE, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10);
    step("bne.de", DE, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10);
`ifdef MC_BNE_EN
    step("bne.bq", BQ, 6'b100000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10);
`else
    step("bne.bq", BQ, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10);
`endif

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    step("jal.fe", FE,  6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b11);
    step("jal.de", DE,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11);
    step("jal.jl", JL,  6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11);
    step("jal.wb", AWB, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11);

    // illegal opcode: one-cycle pulse in DECODE, back to FETCH
    set_instr(7'b1111111, 3'b000, 1'b0);
    step("ill.fe", FE, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    step("ill.de", DE, 6'b000001, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00);

    // reset mid-store drops the MemWrite strobe in the reset cycle
    set_instr(7'b0100011, 3'b010, 1'b0);
    step("rsw.fe", FE, 6'b100100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);
    step("rsw.de", DE, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01);
    step("rsw.ma", MA, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01);
    mem_ready = 1'b0;
    step("rsw.w0", MW, 6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    reset = 1'b0;
    step("rsw.rs", MW, 6'b010000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    reset = 1'b1;
    step("rsw.fs", FE, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the team's multicycle RV32I datapath (shared instruction/data memory, IR/OldPC/ALUOut/Data registers) over several clocks per instruction. It decodes `op`/`funct3`/`funct7b5`, drives every mux select and write enable, and stalls on a memory-ready handshake. Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset (`reset==0` resets on the next `clk` edge)
- `op`  in  7  Instr[6:0]
- `funct3`  in  3  Instr[14:12]
- `funct7b5`  in  1  Instr[30]
- `Zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completed the current access this cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address: 0=PC, 1=ALUOut
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  IR and OldPC enable
- `RegWrite`  out  1  register-file write
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALUResult
- `ALUSrcA`  out  2  00=PC, 01=OldPC, 10=rd1
- `ALUSrcB`  out  2  00=rd2, 01=ImmExt, 10=constant 4
- `ImmSrc`  out  2  00=I, 01=S, 10=B, 11=J
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `illegal`  out  1  one-cycle pulse on an unsupported opcode
- `state`  out  4  current state, for debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL. The state register is the only storage.
- Unlisted outputs are 0 in each state.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite equal `mem_ready`. Stay while `mem_ready=0`; otherwise go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by `op`:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> FETCH with `illegal=1`
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until `mem_ready=1`, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high until the cycle with `mem_ready=1`, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=branch-taken (taken = `Zero` for funct3=000), then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB.
- ImmSrc is combinational from `op` in every state: lw/I-ALU=00, sw=01, beq=10, jal=11, other=00.
- ALU decoder (combinational from internal ALUOp):
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10 by funct3: 000 -> sub if `op[5]&funct7b5`, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.

## Timing
- Next-state register updates on the rising `clk` edge. All outputs are combinational from state plus the listed inputs.
- Reset: while `reset==0`, the next edge loads FETCH. During the reset-asserted cycle, PCWrite, IRWrite, RegWrite, MemWrite and illegal are forced 0 regardless of state.
- Reset mid-instruction aborts it with no partial write: an in-progress MEMWRITE strobe drops in the reset cycle.
- Cycle counts with `mem_ready` tied high:
  - lw 5, sw 4, R/I-type 4, beq 3, jal 4, illegal 2.
- Each FETCH, MEMREAD or MEMWRITE cycle with `mem_ready=0` adds one cycle. Control outputs are held constant throughout the stall.
- `illegal` is high only in the DECODE cycle.

## Configuration
- `MC_BNE_EN` defined: BEQ state also handles funct3=001 (bne), with branch-taken = `~Zero`. Any other branch funct3 is not taken.
- Undefined: branch-taken = `Zero` regardless of funct3.

## Test plan
- Reset held low 2 cycles while forcing other inputs, then released -> `state`=FETCH, all write enables 0 during reset; first IRWrite pulse on the first FETCH cycle after release.
- lw (op=0000011), `mem_ready=1` -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5 only; ImmSrc=00.
- sw with `mem_ready` low for 3 cycles in MEMWRITE -> MemWrite high for 4 consecutive cycles, AdrSrc=1; return to FETCH after the ready cycle.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER. Same with op=0010011 (addi) -> ALUControl=000. funct3=010 -> 101.
- beq with Zero=1 -> PCWrite=1 in BEQ, ALUControl=001, ImmSrc=10. Zero=0 -> PCWrite=0. With `MC_BNE_EN`, funct3=001, Zero=0 -> PCWrite=1.
- op=1111111 -> `illegal` pulses for 1 cycle in DECODE, next state FETCH, no write enables asserted.
